cdc_handshake_tx: RTL and testbench
===================================

// Module: cdc_handshake_tx
//
// PURPOSE
//  Source-domain end of a toggle req/ack bus-crossing handshake.
//  - Captures a WIDTH-bit word from a local valid/ready source and holds it stable on xfer_data.
//  - Announces each word by toggling xfer_req.
//  - Waits for the far-domain receiver to return a matching toggle on xfer_ack.
//  - Lives entirely in the sending clock domain; xfer_ack is asynchronous and is synchronised internally.
//
// PARAMETERS
//  WIDTH        32    data word width, bits
//  SYNC_STAGES  2     flops in xfer_ack synchroniser (legal: 2..4)
//  TIMEOUT      1024  WAIT_ACK cycles before timeout_err sets; 0 = timeout disabled
//
// PORTS
//  clk          in   1      sending-domain clock
//  rst_n        in   1      async assert, active-low reset
//  src_valid    in   1      source word available
//  src_data     in   WIDTH  source word
//  src_ready    out  1      block can accept a word this cycle
//  xfer_data    out  WIDTH  held word, crosses to far domain (quasi-static)
//  xfer_req     out  1      request toggle, crosses to far domain
//  xfer_ack     in   1      ack toggle from far domain, asynchronous to clk
//  xfer_done    out  1      1-cycle pulse when a transfer completes
//  err_clr      in   1      clears timeout_err
//  timeout_err  out  1      sticky: ack not seen within TIMEOUT cycles
//  xfer_count   out  16     completed transfers, wraps at 2^16
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, src_ready=0, xfer_req=0, xfer_data=0, xfer_done=0,
//    timeout_err=0, xfer_count=0, sync flops=0, timer=0.
//  - src_ready is registered. It rises on the first clk edge after rst_n deasserts.
//  - All outputs are registered; no combinational input->output paths.
//  - ack_s = last synchroniser stage of xfer_ack (SYNC_STAGES flops, all reset to 0).
//  - IDLE, with src_ready=1 and src_valid=1 at an edge:
//    - xfer_data<=src_data, xfer_req<=~xfer_req, src_ready<=0, timer<=0.
//    - Go to WAIT_ACK.
//  - IDLE, src_valid=0: hold all state.
//  - WAIT_ACK, ack_s==xfer_req:
//    - Go to IDLE, src_ready<=1, xfer_done<=1 for one cycle.
//    - xfer_count<=xfer_count+1 (wraps from 0xFFFF to 0).
//  - WAIT_ACK, ack_s!=xfer_req: timer increments, saturating at TIMEOUT.
//    - When timer reaches TIMEOUT-1 and TIMEOUT!=0, timeout_err<=1.
//    - State stays WAIT_ACK; there is no retry and no abandon.
//  - xfer_data and xfer_req change only on an accept edge and are otherwise constant.
//    They must not glitch (flop outputs only).
//  - Latency:
//    - Accept edge to xfer_req toggle: 1 cycle.
//    - xfer_ack toggle to xfer_done: SYNC_STAGES+1 cycles.
//    - src_ready re-asserts in the same cycle as xfer_done.
//  - Throughput: at most one word per round trip. Each word holds for at least SYNC_STAGES+2 cycles.
//  - err_clr=1 clears timeout_err. If err_clr and the set condition occur in the same cycle, the set wins.
//  - A spurious ack toggle in IDLE (ack_s!=xfer_req) is ignored. The next accept still toggles xfer_req.
//  - Reset mid-transfer forces IDLE with xfer_req=0, so the far-domain receiver must be reset with it.
//    Resetting only one end leaves the toggle phases mismatched.
//  - The xfer_data/xfer_req paths to the far domain are CDC paths and are constrained as such.
//
// TESTING
//  1. Reset, then src_valid=1 src_data=0xDEADBEEF -> xfer_req 0->1 and xfer_data=0xDEADBEEF one cycle
//     after accept; src_ready=0 until ack.
//  2. Drive xfer_ack 0->1, SYNC_STAGES=2 -> xfer_done high exactly 3 cycles later, src_ready=1,
//     xfer_count=1.
//  3. 100 back-to-back words, receiver model echoes ack after a random 0..20 cycle delay ->
//     all 100 words are seen in order and xfer_count=100.
//  4. TIMEOUT=16 with no ack -> timeout_err=1 after 16 WAIT_ACK cycles and xfer_data is held.
//     A late ack completes the transfer. err_clr clears timeout_err; err_clr coincident with the
//     set condition leaves timeout_err=1.
//  5. rst_n pulsed low mid-WAIT_ACK (async, between edges) -> outputs go to reset values immediately.
//     After release, src_ready=1 on the first edge.
//  6. xfer_count preloaded near wrap (0xFFFF completions) -> the next completion gives xfer_count=0x0000.

Source files
------------

// File: rtl/cdc_handshake_tx_if.sv
// Bus bundle for the source-domain end of a toggle req/ack crossing.
// master: the transmitter block (drives src_ready and the xfer_* outputs).
// slave : the surrounding logic (local source, far-domain ack, error clear).
interface cdc_handshake_tx_if #(
  parameter int WIDTH = 32
);
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             src_ready;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_req;
  logic             xfer_ack;
  logic             xfer_done;
  logic             err_clr;
  logic             timeout_err;
  logic [15:0]      xfer_count;

  modport master (
    input  src_valid,
    input  src_data,
    input  xfer_ack,
    input  err_clr,
    output src_ready,
    output xfer_data,
    output xfer_req,
    output xfer_done,
    output timeout_err,
    output xfer_count
  );

  modport slave (
    output src_valid,
    output src_data,
    output xfer_ack,
    output err_clr,
    input  src_ready,
    input  xfer_data,
    input  xfer_req,
    input  xfer_done,
    input  timeout_err,
    input  xfer_count
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a toggle req/ack handshake. A word accepted from the
// local valid/ready source is parked on xfer_data, announced by toggling
// xfer_req, and released when the synchronised xfer_ack toggle matches the
// request phase. Every output comes straight from a flop so the far domain
// never sees a glitch on the quasi-static data or the request toggle.
module cdc_handshake_tx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input logic                i_clk,
  input logic                i_rst_n,
  cdc_handshake_tx_if.master bus
);

  // Synchroniser depth is held to the legal 2..4 range so a bad override
  // still yields a working crossing instead of an unsynchronised ack.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                          ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

  // Timer must be able to hold TIMEOUT itself, since it saturates there.
  localparam int              TMR_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_SET = (TIMEOUT < 1) ? '0 : TMR_W'(TIMEOUT - 1);
  localparam bit              TMO_EN  = (TIMEOUT > 0);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_src_ready;
  logic [WIDTH-1:0] r_xfer_data;
  logic             r_xfer_req;
  logic             r_xfer_done;
  logic             r_timeout_err;
  logic [15:0]      r_xfer_count;
  logic [TMR_W-1:0] r_timer;
  logic [SYNC_N-1:0] r_ack_sync;

  logic w_ack_s;
  logic w_ack_match;
  logic w_accept;

  // Ack synchroniser: shift the asynchronous toggle through SYNC_N flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_N-2:0], bus.xfer_ack};
    end
  end

  assign w_ack_s     = r_ack_sync[SYNC_N-1];
  // Phases equal means the receiver has consumed the outstanding word.
  assign w_ack_match = (w_ack_s == r_xfer_req);
  assign w_accept    = r_src_ready & bus.src_valid;

  // Handshake FSM with all outputs registered; timeout set is written last so
  // it overrides a coincident err_clr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_src_ready   <= 1'b0;
      r_xfer_data   <= '0;
      r_xfer_req    <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_xfer_count  <= 16'd0;
      r_timer       <= '0;
    end else begin
      r_xfer_done <= 1'b0;
      if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          // A stray ack toggle here is ignored: only an accept moves state.
          if (w_accept) begin
            r_xfer_data <= bus.src_data;
            r_xfer_req  <= ~r_xfer_req;
            r_src_ready <= 1'b0;
            r_timer     <= '0;
            r_state     <= WAIT_ACK;
          end else begin
            r_src_ready <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (w_ack_match) begin
            r_state      <= IDLE;
            r_src_ready  <= 1'b1;
            r_xfer_done  <= 1'b1;
            r_xfer_count <= r_xfer_count + 16'd1;
          end else begin
            if (r_timer != TMR_SAT) begin
              r_timer <= r_timer + 1'b1;
            end
            if (TMO_EN && (r_timer == TMR_SET)) begin
              r_timeout_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready   = r_src_ready;
  assign bus.xfer_data   = r_xfer_data;
  assign bus.xfer_req    = r_xfer_req;
  assign bus.xfer_done   = r_xfer_done;
  assign bus.timeout_err = r_timeout_err;
  assign bus.xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: cycle table for the basic handshake, random
// back-to-back words against a queue-based receiver model, and hand-written
// sequences for timeout, async reset and counter wrap.
module tb_cdc_handshake_tx;
  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdc_handshake_tx_if #(.WIDTH(WIDTH)) bus ();

  cdc_handshake_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  // Far-domain ack: either the random receiver model or the hand sequences.
  logic rx_en = 1'b0;
  logic rx_ack = 1'b0;
  logic man_ack = 1'b0;
  assign bus.xfer_ack = rx_en ? rx_ack : man_ack;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic model_req = 1'b0;
  logic [31:0] rx_q[$];
  logic [31:0] sent_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        clr;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_err;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic v, logic [31:0] d, logic a, logic c,
                              logic r, logic q, logic [31:0] xd, logic dn,
                              logic er, logic [15:0] cnt);
    vec_t t;
    t.valid = v; t.data = d; t.ack = a; t.clr = c;
    t.e_ready = r; t.e_req = q; t.e_data = xd; t.e_done = dn;
    t.e_err = er; t.e_count = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Complete one transfer driven by the bench with an immediate ack echo.
  task automatic xfer(input logic [31:0] w, input string tag);
    bus.src_data  = w;
    bus.src_valid = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    model_req = ~model_req;
    check({tag, "_req"}, 32'(bus.xfer_req), 32'(model_req));
    check({tag, "_data"}, bus.xfer_data, w);
    man_ack = model_req;
    repeat (SYNC + 1) tick();
    check({tag, "_done"}, 32'(bus.xfer_done), 32'(1));
    check({tag, "_ready"}, 32'(bus.src_ready), 32'(1));
    $display("xfer %s word 0x%08h count=0x%04h", tag, w, bus.xfer_count);
  endtask

  // Done-pulse counter.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.xfer_done) done_cnt++;
    end
  end

  // Receiver model: on each request toggle capture the word, then echo the
  // toggle after a random 0..20 cycle delay.
  initial begin
    logic rx_last;
    int d;
    rx_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rx_en) begin
        rx_last = bus.xfer_req;
        rx_ack  = man_ack;
      end else if (bus.xfer_req != rx_last) begin
        rx_last = bus.xfer_req;
        rx_q.push_back(bus.xfer_data);
        d = $urandom_range(0, 20);
        repeat (d) @(negedge clk);
        rx_ack = rx_last;
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int guard;
    int done_before;
    logic [31:0] word;

    //        valid data          ack clr | ready req xdata         done err count
    tbl[0]  = mk(0, 32'h0,        0, 0,     1, 0, 32'h0,        0, 0, 16'd0);
    tbl[1]  = mk(1, 32'hDEADBEEF, 0, 0,     0, 1, 32'hDEADBEEF, 0, 0, 16'd0);
    tbl[2]  = mk(0, 32'h0,        0, 0,     0, 1, 32'hDEADBEEF, 0, 0, 16'd0);
    tbl[3]  = mk(1, 32'h12345678, 0, 0,     0, 1, 32'hDEADBEEF, 0, 0, 16'd0);
    tbl[4]  = mk(0, 32'h0,        1, 0,     0, 1, 32'hDEADBEEF, 0, 0, 16'd0);
    tbl[5]  = mk(0, 32'h0,        1, 0,     0, 1, 32'hDEADBEEF, 0, 0, 16'd0);
    tbl[6]  = mk(0, 32'h0,        1, 0,     1, 1, 32'hDEADBEEF, 1, 0, 16'd1);
    tbl[7]  = mk(0, 32'h0,        1, 0,     1, 1, 32'hDEADBEEF, 0, 0, 16'd1);
    tbl[8]  = mk(1, 32'hCAFEF00D, 1, 0,     0, 0, 32'hCAFEF00D, 0, 0, 16'd1);
    tbl[9]  = mk(0, 32'h0,        1, 0,     0, 0, 32'hCAFEF00D, 0, 0, 16'd1);
    tbl[10] = mk(0, 32'h0,        0, 0,     0, 0, 32'hCAFEF00D, 0, 0, 16'd1);
    tbl[11] = mk(0, 32'h0,        0, 0,     0, 0, 32'hCAFEF00D, 0, 0, 16'd1);
    tbl[12] = mk(0, 32'h0,        0, 0,     1, 0, 32'hCAFEF00D, 1, 0, 16'd2);
    tbl[13] = mk(0, 32'h0,        0, 1,     1, 0, 32'hCAFEF00D, 0, 0, 16'd2);
    tbl[14] = mk(0, 32'h0,        1, 0,     1, 0, 32'hCAFEF00D, 0, 0, 16'd2);
    tbl[15] = mk(0, 32'h0,        1, 0,     1, 0, 32'hCAFEF00D, 0, 0, 16'd2);
    tbl[16] = mk(0, 32'h0,        1, 0,     1, 0, 32'hCAFEF00D, 0, 0, 16'd2);
    tbl[17] = mk(1, 32'h0BADF00D, 1, 0,     0, 1, 32'h0BADF00D, 0, 0, 16'd2);
    tbl[18] = mk(0, 32'h0,        1, 0,     1, 1, 32'h0BADF00D, 1, 0, 16'd3);
    tbl[19] = mk(0, 32'h0,        1, 0,     1, 1, 32'h0BADF00D, 0, 0, 16'd3);

    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.err_clr   = 1'b0;
    man_ack       = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.src_ready), 32'(0));
    check("rst_req", 32'(bus.xfer_req), 32'(0));
    check("rst_data", bus.xfer_data, 32'h0);
    check("rst_done", 32'(bus.xfer_done), 32'(0));
    check("rst_err", 32'(bus.timeout_err), 32'(0));
    check("rst_count", 32'(bus.xfer_count), 32'(0));
    rst_n = 1'b1;

    // Cycle table: accept, 3-cycle ack latency, spurious ack in IDLE.
    for (int i = 0; i < 20; i++) begin
      bus.src_valid = tbl[i].valid;
      bus.src_data  = tbl[i].data;
      bus.err_clr   = tbl[i].clr;
      man_ack       = tbl[i].ack;
      tick();
      check($sformatf("v%0d_ready", i), 32'(bus.src_ready), 32'(tbl[i].e_ready));
      check($sformatf("v%0d_req", i), 32'(bus.xfer_req), 32'(tbl[i].e_req));
      check($sformatf("v%0d_data", i), bus.xfer_data, tbl[i].e_data);
      check($sformatf("v%0d_done", i), 32'(bus.xfer_done), 32'(tbl[i].e_done));
      check($sformatf("v%0d_err", i), 32'(bus.timeout_err), 32'(tbl[i].e_err));
      check($sformatf("v%0d_count", i), 32'(bus.xfer_count), 32'(tbl[i].e_count));
      $display("vec %0d: valid=%0b data=0x%08h ack=%0b clr=%0b -> ready=%0b req=%0b done=%0b count=%0d",
               i, tbl[i].valid, tbl[i].data, tbl[i].ack, tbl[i].clr,
               bus.src_ready, bus.xfer_req, bus.xfer_done, bus.xfer_count);
    end
    bus.src_valid = 1'b0;
    bus.err_clr   = 1'b0;
    model_req     = 1'b1;

    // Random back-to-back words with a delayed-echo receiver.
    done_before = done_cnt;
    rx_en = 1'b1;
    for (int w = 0; w < 100; w++) begin
      word = $urandom;
      bus.src_data  = word;
      bus.src_valid = 1'b1;
      guard = 0;
      while (!bus.src_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) begin
        check("rand_accept", 32'(bus.src_ready), 32'(1));
        break;
      end
      tick();
      sent_q.push_back(word);
      model_req = ~model_req;
      $display("rand word %0d sent 0x%08h", w, word);
    end
    bus.src_valid = 1'b0;
    guard = 0;
    while ((rx_q.size() < sent_q.size() || !bus.src_ready) && guard < 1000) begin
      tick();
      guard++;
    end
    tick();
    check("rand_rx_words", 32'(rx_q.size()), 32'(100));
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
      check($sformatf("rand_word%0d", i), rx_q[i], sent_q[i]);
    end
    check("rand_count", 32'(bus.xfer_count), 32'(103));
    check("rand_done_pulses", 32'(done_cnt - done_before), 32'(100));
    check("rand_req_phase", 32'(bus.xfer_req), 32'(model_req));
    man_ack = rx_ack;
    rx_en   = 1'b0;

    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("pre_tmo_clr", 32'(bus.timeout_err), 32'(0));

    // Timeout without ack, then late ack completes.
    bus.src_data  = 32'h5A5A1234;
    bus.src_valid = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    model_req = ~model_req;
    repeat (TMO - 1) tick();
    check("tmo_before", 32'(bus.timeout_err), 32'(0));
    tick();
    check("tmo_set", 32'(bus.timeout_err), 32'(1));
    check("tmo_data_held", bus.xfer_data, 32'h5A5A1234);
    check("tmo_req_held", 32'(bus.xfer_req), 32'(model_req));
    check("tmo_ready", 32'(bus.src_ready), 32'(0));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_clr", 32'(bus.timeout_err), 32'(0));
    repeat (5) tick();
    check("tmo_no_reset", 32'(bus.timeout_err), 32'(0));
    man_ack = model_req;
    repeat (SYNC) tick();
    check("late_ack_pending", 32'(bus.xfer_done), 32'(0));
    tick();
    check("late_ack_done", 32'(bus.xfer_done), 32'(1));
    check("late_ack_count", 32'(bus.xfer_count), 32'(104));
    $display("timeout transfer completed by late ack, count=%0d", bus.xfer_count);

    // err_clr held through the set cycle: set wins.
    bus.src_data  = 32'hA5A5F00F;
    bus.src_valid = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    model_req = ~model_req;
    bus.err_clr = 1'b1;
    repeat (TMO - 1) tick();
    check("coinc_before", 32'(bus.timeout_err), 32'(0));
    tick();
    check("coinc_set_wins", 32'(bus.timeout_err), 32'(1));
    tick();
    check("coinc_clr_after", 32'(bus.timeout_err), 32'(0));
    bus.err_clr = 1'b0;
    man_ack = model_req;
    repeat (SYNC + 1) tick();
    check("coinc_done", 32'(bus.xfer_done), 32'(1));
    check("coinc_count", 32'(bus.xfer_count), 32'(105));
    $display("coincident clear/set transfer completed, count=%0d", bus.xfer_count);

    // Async reset mid-WAIT_ACK.
    bus.src_data  = 32'h13579BDF;
    bus.src_valid = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    model_req = ~model_req;
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.src_ready), 32'(0));
    check("arst_req", 32'(bus.xfer_req), 32'(0));
    check("arst_data", bus.xfer_data, 32'h0);
    check("arst_count", 32'(bus.xfer_count), 32'(0));
    check("arst_err", 32'(bus.timeout_err), 32'(0));
    man_ack   = 1'b0;
    model_req = 1'b0;
    tick();
    tick();
    check("arst_hold_ready", 32'(bus.src_ready), 32'(0));
    rst_n = 1'b1;
    tick();
    check("arst_rel_ready", 32'(bus.src_ready), 32'(1));
    check("arst_rel_req", 32'(bus.xfer_req), 32'(0));
    $display("async reset mid-transfer, ready after release=%0b", bus.src_ready);

    // Counter wrap from a preloaded value.
    dut.r_xfer_count = 16'hFFFE;
    xfer(32'h11112222, "wrap_a");
    check("wrap_ffff", 32'(bus.xfer_count), 32'h0000FFFF);
    xfer(32'h33334444, "wrap_b");
    check("wrap_zero", 32'(bus.xfer_count), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
